// File: rtl/uart_word_ctrl.sv
// Word-level sequencer between the byte uart and network logic: RX byte assembly, TX word serialization.
// Optional inter-byte idle timeout on the RX side is built when UART_WORD_CTRL_RX_TIMEOUT_EN is defined.
module uart_word_ctrl #(
    parameter int unsigned WORD_BYTES = 2,
    parameter int unsigned RX_TIMEOUT = 25000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_new_value,
    input  logic [7:0]              uart_recvd_data,
    input  logic                    uart_error,
    input  logic                    uart_busy,
    output logic                    uart_clear,
    output logic                    uart_start,
    output logic [7:0]              uart_data,
    output logic [8*WORD_BYTES-1:0] rx_word,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    input  logic [8*WORD_BYTES-1:0] tx_word,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    frame_error,
    output logic                    overrun,
    output logic                    rx_timeout
);

    localparam int unsigned W     = 8 * WORD_BYTES;
    localparam int unsigned CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_ARB, TX_START, TX_GUARD, TX_DRAIN} tx_state_t;

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [W-1:0]     r_asm;
    logic [W-1:0]     r_rx_word;
    logic             r_rx_valid;
    logic             r_uart_clear;
    logic             r_frame_error;
    logic             r_overrun;
    logic [W-1:0]     w_asm_next;
    logic             w_hold_free;

    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_idx;
    logic [W-1:0]     r_tx_word;
    logic [1:0]       r_guard;
    logic             r_tx_ready;
    logic             r_uart_start;
    logic [7:0]       r_uart_data;

    // Current partial word with the incoming byte dropped into its LSB-first slot
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[32'(r_rx_cnt) * 8 +: 8] = uart_recvd_data;
    end

    assign w_hold_free = !r_rx_valid || rx_ready;

`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(RX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_rx_timeout;
    assign rx_timeout = r_rx_timeout;
`else
    // Feature absent: output tied off
    assign rx_timeout = 1'b0 & (RX_TIMEOUT == 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state    <= RX_IDLE;
            r_rx_cnt      <= '0;
            r_asm         <= '0;
            r_rx_word     <= '0;
            r_rx_valid    <= 1'b0;
            r_uart_clear  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_rx_timeout  <= 1'b0;
`endif
        end else begin
            r_uart_clear  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (uart_new_value) begin
                        r_uart_clear <= 1'b1;
                        r_rx_state   <= RX_ACK;
                        if (uart_error) begin
                            r_asm         <= '0;
                            r_rx_cnt      <= '0;
                            r_frame_error <= 1'b1;
                        end else if (r_rx_cnt == LAST_BYTE) begin
                            r_asm    <= '0;
                            r_rx_cnt <= '0;
                            if (w_hold_free) begin
                                r_rx_word  <= w_asm_next;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_asm    <= w_asm_next;
                            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                        end
                    end
                end
                RX_ACK:  r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
            // Idle timer only runs while a partial word is pending
            r_rx_timeout <= 1'b0;
            if (r_rx_state == RX_IDLE && uart_new_value) begin
                r_to_cnt <= '0;
            end else if (r_rx_state == RX_IDLE && r_rx_cnt != '0) begin
                if (r_to_cnt == TO_LAST) begin
                    r_to_cnt     <= '0;
                    r_asm        <= '0;
                    r_rx_cnt     <= '0;
                    r_rx_timeout <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
`endif
        end
    end

    // TX: one byte at a time, deferring to any uart activity before each start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state   <= TX_IDLE;
            r_tx_idx     <= '0;
            r_tx_word    <= '0;
            r_guard      <= '0;
            r_tx_ready   <= 1'b1;
            r_uart_start <= 1'b0;
            r_uart_data  <= '0;
        end else begin
            r_uart_start <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_valid && r_tx_ready) begin
                        r_tx_word  <= tx_word;
                        r_tx_idx   <= '0;
                        r_tx_ready <= 1'b0;
                        r_tx_state <= TX_ARB;
                    end
                end
                TX_ARB: begin
                    if (!uart_busy) begin
                        r_uart_start <= 1'b1;
                        r_uart_data  <= r_tx_word[32'(r_tx_idx) * 8 +: 8];
                        r_tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    r_guard    <= '0;
                    r_tx_state <= TX_GUARD;
                end
                TX_GUARD: begin
                    // Give the uart up to 4 cycles to raise busy
                    if (uart_busy || r_guard == 2'd3) begin
                        r_tx_state <= TX_DRAIN;
                    end else begin
                        r_guard <= r_guard + 2'd1;
                    end
                end
                TX_DRAIN: begin
                    if (!uart_busy) begin
                        if (r_tx_idx == LAST_BYTE) begin
                            r_tx_ready <= 1'b1;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_idx   <= r_tx_idx + CNT_W'(1);
                            r_tx_state <= TX_ARB;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign uart_clear  = r_uart_clear;
    assign uart_start  = r_uart_start;
    assign uart_data   = r_uart_data;
    assign rx_word     = r_rx_word;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = r_tx_ready;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Directed bench for uart_word_ctrl (WORD_BYTES=2, RX_TIMEOUT=50) with a behavioural uart model.
module tb_uart_word_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_new_value;
    logic [7:0]  uart_recvd_data;
    logic        uart_error;
    logic        uart_busy;
    logic        uart_clear;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic [15:0] rx_word;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_word;
    logic        tx_valid;
    logic        tx_ready;
    logic        frame_error;
    logic        overrun;
    logic        rx_timeout;

    logic        rx_busy_tb;
    int          tx_busy_cnt = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_clear = 0, n_start = 0, n_ferr = 0, n_ovr = 0, n_to = 0;
    logic [7:0] st_data [8];
    logic       st_busy [8];

    uart_word_ctrl #(.WORD_BYTES(2), .RX_TIMEOUT(50)) dut (
        .clk(clk), .rst(rst),
        .uart_new_value(uart_new_value), .uart_recvd_data(uart_recvd_data),
        .uart_error(uart_error), .uart_busy(uart_busy),
        .uart_clear(uart_clear), .uart_start(uart_start), .uart_data(uart_data),
        .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_error(frame_error), .overrun(overrun), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    // Uart transmitter model: busy for 20 cycles after each start
    always @(posedge clk) begin
        if (uart_start) tx_busy_cnt <= 20;
        else if (tx_busy_cnt != 0) tx_busy_cnt <= tx_busy_cnt - 1;
    end
    assign uart_busy = rx_busy_tb | (tx_busy_cnt != 0);

    // Pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (uart_clear) n_clear++;
        if (uart_start) begin
            if (n_start < 8) begin
                st_data[n_start] = uart_data;
                st_busy[n_start] = uart_busy;
            end
            n_start++;
        end
        if (frame_error) n_ferr++;
        if (overrun)     n_ovr++;
        if (rx_timeout)  n_to++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one byte and wait (bounded) for the clear; returns #1 after the clear edge
    task automatic send_byte(input logic [7:0] b, input logic err);
        bit seen = 0;
        @(negedge clk);
        uart_recvd_data = b;
        uart_error      = err;
        uart_new_value  = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (uart_clear) seen = 1;
        end
        uart_new_value = 1'b0;
        uart_error     = 1'b0;
        chk("clear_seen", 64'(seen), 64'd1);
        #1;
    endtask

    task automatic wait_tx_done();
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (tx_ready) done = 1;
        end
        chk("tx_done", 64'(done), 64'd1);
        #1;
    endtask

    task automatic consume();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("consume_valid", 64'(rx_valid), 64'd0);
    endtask

    int c0, s0, e0, o0, t0;

    initial begin
        rst = 1'b1; uart_new_value = 0; uart_recvd_data = 0; uart_error = 0;
        rx_ready = 0; tx_word = 0; tx_valid = 0; rx_busy_tb = 0;
        repeat (3) @(negedge clk);
        chk("rst_clear", 64'(uart_clear), 64'd0);
        chk("rst_start", 64'(uart_start), 64'd0);
        chk("rst_rx_valid", 64'(rx_valid), 64'd0);
        chk("rst_tx_ready", 64'(tx_ready), 64'd1);
        chk("rst_pulses", 64'({frame_error, overrun, rx_timeout}), 64'd0);
        chk("rst_data", 64'(uart_data), 64'd0);
        rst = 1'b0;

        // RX assembly
        c0 = n_clear;
        send_byte(8'h34, 1'b0);
        chk("asm_first_valid", 64'(rx_valid), 64'd0);
        send_byte(8'h12, 1'b0);
        chk("asm_valid", 64'(rx_valid), 64'd1);
        chk("asm_word", 64'(rx_word), 64'h1234);
        chk("asm_clears", 64'(n_clear - c0), 64'd2);
        consume();

        // TX serialization
        s0 = n_start;
        @(negedge clk);
        tx_word = 16'hBEEF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("tx_ready_low", 64'(tx_ready), 64'd0);
        chk("tx_no_start_t1", 64'(uart_start), 64'd0);
        @(negedge clk);
        chk("tx_start_t2", 64'(uart_start), 64'd1);
        chk("tx_byte0", 64'(uart_data), 64'hEF);
        wait_tx_done();
        chk("tx_starts", 64'(n_start - s0), 64'd2);
        chk("tx_byte1", 64'(st_data[s0+1]), 64'hBE);
        chk("tx_byte1_idle", 64'(st_busy[s0+1]), 64'd0);

        // Arbitration against an in-progress reception
        s0 = n_start;
        @(negedge clk);
        rx_busy_tb = 1'b1;
        tx_word = 16'h1357; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("arb_held", 64'(n_start - s0), 64'd0);
        rx_busy_tb = 1'b0;
        @(negedge clk);
        chk("arb_start", 64'(uart_start), 64'd1);
        chk("arb_byte0", 64'(uart_data), 64'h57);
        wait_tx_done();

        // Overrun with the consumer stalled
        o0 = n_ovr;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        chk("ovr_count", 64'(n_ovr - o0), 64'd1);
        chk("ovr_word", 64'(rx_word), 64'h0201);
        chk("ovr_valid", 64'(rx_valid), 64'd1);
        consume();

        // Framing error discards the partial word
        e0 = n_ferr;
        send_byte(8'h55, 1'b0);
        send_byte(8'hFF, 1'b1);
        chk("ferr_count", 64'(n_ferr - e0), 64'd1);
        chk("ferr_no_valid", 64'(rx_valid), 64'd0);
        send_byte(8'h0A, 1'b0);
        send_byte(8'h0B, 1'b0);
        chk("ferr_word", 64'(rx_word), 64'h0B0A);
        chk("ferr_valid", 64'(rx_valid), 64'd1);
        consume();

        // Idle timeout (or persistence of the partial word when not built)
        t0 = n_to;
        send_byte(8'h99, 1'b0);
        repeat (60) @(negedge clk);
        #1;
`ifdef UART_WORD_CTRL_RX_TIMEOUT_EN
        chk("to_count", 64'(n_to - t0), 64'd1);
        send_byte(8'h11, 1'b0);
        chk("to_mid_valid", 64'(rx_valid), 64'd0);
        send_byte(8'h22, 1'b0);
        chk("to_word", 64'(rx_word), 64'h2211);
`else
        chk("to_count", 64'(n_to - t0), 64'd0);
        send_byte(8'h11, 1'b0);
        chk("to_word", 64'(rx_word), 64'h1199);
`endif
        chk("to_valid", 64'(rx_valid), 64'd1);
        consume();

        // Reset mid-operation
        send_byte(8'h77, 1'b0);
        @(negedge clk);
        tx_word = 16'hAAAA; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_tx_ready", 64'(tx_ready), 64'd1);
        chk("mrst_start", 64'(uart_start), 64'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        chk("mrst_word", 64'(rx_word), 64'h0201);
        chk("mrst_valid", 64'(rx_valid), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
